// File: rtl/fp64Pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp64Pkg (package)
// Purpose  : Shared IEEE-754 binary64 type and field boundaries.
//            FP64 : 64-bit raw encoding {sign, exponent[10:0], fraction[51:0]}
//            EMSB : MSB of the exponent field
//            FMSB : MSB of the fraction field
// Revision : 1.0 - initial release
// ============================================================================
package fp64Pkg;

  typedef logic [63:0] FP64;

  localparam int EMSB = 62;
  localparam int FMSB = 51;

endpackage
`default_nettype wire

// File: rtl/fp_scaleb64_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_scaleb64_arb_if (interface)
// Purpose  : Request/response bundle for the arbitrated FP64 scaleb unit.
// Signals  : req_valid  [NREQ]      per-requester operation valid
//            req_ready  [NREQ]      per-requester accept (one-hot or zero)
//            req_a      [NREQ]xFP64 operand a
//            req_b      [NREQ]xFP64 scale operand b (two's complement int)
//            resp_valid             result valid
//            resp_ready             consumer accepts result
//            resp_o     FP64        scaleb result
//            resp_id    [IDW]       requester owning resp_o
// Modports : master (requesters + consumer side), slave (the arbiter unit)
// Revision : 1.0 - initial release
// ============================================================================
interface fp_scaleb64_arb_if
  import fp64Pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  FP64  [NREQ-1:0] req_a;
  FP64  [NREQ-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  FP64             resp_o;
  logic [IDW-1:0]  resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_o, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_o, resp_id
  );

endinterface
`default_nettype wire

// File: rtl/fpScaleb64.sv
`default_nettype none
// ============================================================================
// Module   : fpScaleb64
// Purpose  : Two-stage FP64 scaleb: result = a * 2^b, b a signed integer.
//            Stage 1 computes the new biased exponent, stage 2 formats.
//            NaN, infinity and zero/subnormal a pass through unchanged.
//            Exponent overflow gives signed infinity; underflow forces the
//            exponent field to 0 while keeping sign and fraction.
// Ports    : clk      clock
//            ce       clock enable for both stages
//            a_i      FP64 operand
//            b_i      64-bit two's complement scale amount
//            res_o    FP64 result, two enabled cycles after a_i/b_i
// Revision : 1.0 - initial release
// ============================================================================
module fpScaleb64
  import fp64Pkg::*;
(
  input  logic clk,
  input  logic ce,
  input  FP64  a_i,
  input  FP64  b_i,
  output FP64  res_o
);

  // Any |b| beyond the exponent span saturates the same way, so clamping
  // b into 13 bits keeps the adder narrow without changing results.
  localparam logic signed [13:0] B_MAX = 14'sd4095;
  localparam logic signed [13:0] B_MIN = -14'sd4096;

  logic [EMSB-FMSB-1:0] exp_w;
  logic                 pass_d;
  logic signed [13:0]   bclamp_d;
  logic signed [13:0]   ne_d;

  FP64                  a_q;
  logic                 pass_q;
  logic signed [13:0]   ne_q;

  FP64                  res_d;
  FP64                  res_q;

  // Stage 1: exponent arithmetic
  always_comb begin
    exp_w  = a_i[EMSB:FMSB+1];
    pass_d = (exp_w == '1) || (exp_w == '0);
    if ($signed(b_i) > 64'sd4095) begin
      bclamp_d = B_MAX;
    end else if ($signed(b_i) < -64'sd4096) begin
      bclamp_d = B_MIN;
    end else begin
      bclamp_d = $signed(b_i[13:0]);
    end
    ne_d = $signed({3'b000, exp_w}) + bclamp_d;
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      a_q    <= a_i;
      pass_q <= pass_d;
      ne_q   <= ne_d;
    end
  end

  // Stage 2: classify and assemble
  always_comb begin
    res_d = a_q;
    if (pass_q) begin
      res_d = a_q;
    end else if (ne_q >= 14'sd2047) begin
      res_d = {a_q[63], 11'h7FF, 52'd0};
    end else if (ne_q <= 14'sd0) begin
      res_d = {a_q[63], 11'h000, a_q[FMSB:0]};
    end else begin
      res_d = {a_q[63], ne_q[10:0], a_q[FMSB:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule
`default_nettype wire

// File: rtl/fp_scaleb64_arb.sv
`default_nettype none
// ============================================================================
// Module   : fp_scaleb64_arb
// Purpose  : Round-robin arbiter in front of one shared two-stage fpScaleb64.
//            Up to NREQ requesters; results return in acceptance order,
//            tagged with the owning requester id. Latency 2, one op/cycle.
// Ports    : clk         clock (rising edge)
//            rst         synchronous active-high reset
//            bus         fp_scaleb64_arb_if.slave (request/response bundle)
//            perf_grant  [NREQ]x32 accepted transfers per requester (opt.)
//            perf_stall  32-bit count of resp_valid & ~resp_ready cycles (opt.)
// Options  : FPSCALEB_ARB_PERF_EN adds the perf_grant/perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fp_scaleb64_arb
  import fp64Pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
)
(
  input  logic clk,
  input  logic rst,
  fp_scaleb64_arb_if.slave bus
`ifdef FPSCALEB_ARB_PERF_EN
  ,
  output logic [NREQ-1:0][31:0] perf_grant,
  output logic [31:0]           perf_stall
`endif
);

  logic            adv;
  logic            gnt_any_d;
  logic [IDW-1:0]  gnt_idx_d;
  logic [NREQ-1:0] ready_d;
  logic [NREQ-1:0] fire_vec;
  logic            fire;

  logic [IDW-1:0]  last_q;
  logic            v1_q;
  logic            v2_q;
  logic [IDW-1:0]  id1_q;
  logic [IDW-1:0]  id2_q;

  FP64             a_sel;
  FP64             b_sel;
  FP64             res;

  // The output stage is free when empty or being drained this cycle.
  assign adv = ~v2_q | bus.resp_ready;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    gnt_any_d = 1'b0;
    gnt_idx_d = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any_d && (j == ((int'(last_q) + k) % NREQ)) && bus.req_valid[j]) begin
          gnt_any_d = 1'b1;
          gnt_idx_d = IDW'(j);
        end
      end
    end
  end

  // Ready is only offered while the pipeline can move and not in reset.
  always_comb begin
    ready_d = '0;
    for (int j = 0; j < NREQ; j++) begin
      ready_d[j] = gnt_any_d && adv && !rst && (gnt_idx_d == IDW'(j));
    end
  end

  assign bus.req_ready = ready_d;
  assign fire_vec      = bus.req_valid & ready_d;
  assign fire          = |fire_vec;

  assign a_sel = bus.req_a[gnt_idx_d];
  assign b_sel = bus.req_b[gnt_idx_d];

  // Valid pipeline and last-granted pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      if (fire) begin
        last_q <= gnt_idx_d;
      end
      if (adv) begin
        v1_q <= fire;
        v2_q <= v1_q;
      end
    end
  end

  // Id tags travel with the data; qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      id1_q <= gnt_idx_d;
      id2_q <= id1_q;
    end
  end

  fpScaleb64 u_scaleb (
    .clk   (clk),
    .ce    (adv),
    .a_i   (a_sel),
    .b_i   (b_sel),
    .res_o (res)
  );

  // Reset masks the output immediately so in-flight work never appears.
  assign bus.resp_valid = v2_q & ~rst;
  assign bus.resp_o     = res;
  assign bus.resp_id    = id2_q;

`ifdef FPSCALEB_ARB_PERF_EN
  logic [NREQ-1:0][31:0] perf_grant_q;
  logic [31:0]           perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        if (fire_vec[j]) begin
          perf_grant_q[j] <= perf_grant_q[j] + 32'd1;
        end
      end
      if (bus.resp_valid && !bus.resp_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_grant = perf_grant_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_scaleb64_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_scaleb64_arb
// Purpose  : Directed scoreboard bench for fp_scaleb64_arb (NREQ = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_scaleb64_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_scaleb64_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef FPSCALEB_ARB_PERF_EN
  logic [NREQ-1:0][31:0] perf_grant;
  logic [31:0]           perf_stall;
  logic [31:0]           stall_base;
`endif

  fp_scaleb64_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FPSCALEB_ARB_PERF_EN
    ,
    .perf_grant (perf_grant),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] exp_res [NREQ];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pushes expectations on accepted requests, pops on responses.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      chk(bus.resp_valid == 1'b0, "rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk(bus.req_ready == '0, "rst_req_ready", 64'(bus.req_ready), 64'd0);
    end else begin
      chk($countones(bus.req_ready) <= 1, "ready_onehot", 64'(bus.req_ready), 64'd0);
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_resp", bus.resp_o, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(bus.resp_id == e.id, "resp_id", 64'(bus.resp_id), 64'(e.id));
          chk(bus.resp_o == e.res, "resp_o", bus.resp_o, e.res);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_t e;
          e.id  = IDW'(i);
          e.res = exp_res[i];
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    bus.req_a[i] = a;
    bus.req_b[i] = b;
    exp_res[i]   = r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.resp_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'd0, 64'd0, 64'd0);
    repeat (3) tick();

    // Single op: 1.0 scaled by 2^3, latency 2
    set_req(0, 64'h3FF0000000000000, 64'd3, 64'h4020000000000000);
    rst           = 1'b0;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk(bus.req_ready == 4'b0001, "single_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk(bus.resp_valid == 1'b0, "latency_n1", 64'(bus.resp_valid), 64'd0);
    tick();
    @(negedge clk);
    chk(bus.resp_valid == 1'b1, "latency_n2", 64'(bus.resp_valid), 64'd1);
    tick();
    drain();

    // Round robin with all requesters valid, mixed special cases
    set_req(0, 64'h3FF0000000000000, 64'd3, 64'h4020000000000000);
    set_req(1, 64'h4000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h3FF0000000000000);
    set_req(2, 64'h7FE0000000000000, 64'd10, 64'h7FF0000000000000);
    set_req(3, 64'h7FF8000000000001, 64'd5, 64'h7FF8000000000001);
    rst = 1'b1;
    repeat (2) tick();
    rst           = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] want;
      want = 4'b0001 << (k % 4);
      @(negedge clk);
      chk(bus.req_ready == want, "rr_grant", 64'(bus.req_ready), 64'(want));
      tick();
    end
    bus.req_valid = 4'b0000;
    drain();
`ifdef FPSCALEB_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) begin
      chk(perf_grant[i] == 32'd2, "perf_grant", 64'(perf_grant[i]), 64'd2);
    end
`endif

    // Backpressure with a full pipeline; second op underflows
    set_req(0, 64'h4000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h3FF0000000000000);
    set_req(1, 64'h8018000000000000, 64'hFFFFFFFFFFFFFFFB, 64'h8008000000000000);
    bus.req_valid = 4'b0011;
    tick();
    tick();
    bus.resp_ready = 1'b0;
`ifdef FPSCALEB_ARB_PERF_EN
    stall_base = perf_stall;
`endif
    repeat (5) begin
      @(negedge clk);
      chk(bus.req_ready == 4'b0000, "stall_ready", 64'(bus.req_ready), 64'd0);
      chk(bus.resp_valid == 1'b1, "stall_valid", 64'(bus.resp_valid), 64'd1);
      chk(bus.resp_o == 64'h3FF0000000000000, "stall_hold", bus.resp_o, 64'h3FF0000000000000);
      tick();
    end
`ifdef FPSCALEB_ARB_PERF_EN
    chk(perf_stall - stall_base == 32'd5, "perf_stall", 64'(perf_stall - stall_base), 64'd5);
`endif
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0000;
    drain();

    // Reset while two operations are in flight
    bus.req_valid = 4'b0011;
    tick();
    tick();
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    repeat (2) tick();
    set_req(0, 64'hC000000000000000, 64'd1, 64'hC010000000000000);
    rst           = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk(bus.req_ready == 4'b0001, "post_rst_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 4'b0000;
    drain();
    repeat (3) tick();
    chk(sb.size() == 0, "final_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_scaleb64_arb.md
FP_SCALEB64_ARB -- requirements
Module: fp_scaleb64_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter IDW, default $clog2(NREQ), giving the requester-id width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester operation valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept; at most one bit high per cycle.
REQ-007 The block SHALL have port req_a, input, NREQ x FP64: per-requester operand a.
REQ-008 The block SHALL have port req_b, input, NREQ x FP64: per-requester scale operand b.
REQ-009 The block SHALL have port resp_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port resp_ready, input, 1 bit: consumer accepts result.
REQ-011 The block SHALL have port resp_o, output, FP64: scaleb result.
REQ-012 The block SHALL have port resp_id, output, IDW bits: index of the requester owning resp_o.

Function
REQ-013 A transfer SHALL occur on req[i] when req_valid[i] and req_ready[i] are both high; on resp when resp_valid and resp_ready are both high.
REQ-014 Pipeline advance SHALL be adv = ~v2 | resp_ready, where v2 is stage-2 valid; adv SHALL drive the datapath ce.
REQ-015 Grant SHALL be round-robin: the search starts at last-granted index + 1 mod NREQ, and the first requester with req_valid high is granted.
REQ-016 req_ready[g] SHALL be high only for the granted index g, only when adv is high; req_ready SHALL depend combinationally on req_valid and must not be required before req_valid.
REQ-017 The last-granted pointer SHALL update only on an accepted transfer; with no transfer it SHALL hold.
REQ-018 The id and valid pipeline (v1, id1, v2, id2) SHALL shift in lock-step with the datapath when adv is high and hold otherwise.
REQ-019 Latency SHALL be 2 cycles: an operation accepted in cycle N presents resp_valid in cycle N+2 when resp_ready has been high.
REQ-020 Throughput SHALL be one operation per cycle while resp_ready is high.
REQ-021 With resp_valid high and resp_ready low, resp_o and resp_id SHALL remain stable, and no request SHALL be accepted.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 resp_o SHALL be bit-exact to the scaleb datapath:
- NaN a: passes through.
- Exponent overflow: yields signed infinity.
- Exponent underflow: exponent forced to 0.
REQ-024 With no req_valid high, the pointer SHALL hold and a bubble (v1 = 0) SHALL enter the pipeline when adv is high.

Reset
REQ-025 While rst is high, v1, v2, resp_valid and req_ready SHALL be 0; the last-granted pointer SHALL be NREQ-1, so that index 0 has first priority.
REQ-026 rst asserted mid-operation SHALL discard all in-flight operations without producing responses.
REQ-027 No request SHALL be accepted in the cycle rst is high.
REQ-028 Datapath data registers need not be reset, since they are qualified by valid.

Configuration
REQ-029 With macro FPSCALEB_ARB_PERF_EN defined, the block SHALL add the following ports, each counter reset to 0 and wrapping at 2^32:
- perf_grant: output, NREQ x 32 bits; counts accepted transfers per requester.
- perf_stall: output, 32 bits; counts cycles with resp_valid high and resp_ready low.
REQ-030 Without FPSCALEB_ARB_PERF_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-031 The FP64 type, EMSB and FMSB SHALL come from fp64Pkg; no new package types are needed.
REQ-032 The block SHALL instantiate exactly one fpScaleb64, with ce = adv; the round-robin arbiter MAY be a local function or an always_comb block rather than a sub-module.

Verification
REQ-033 Reset, then req_valid=0001 with a=0x3FF0000000000000 (1.0) and b=3, resp_ready=1 -> resp_valid in cycle N+2 with resp_o=0x4020000000000000 and resp_id=0.
REQ-034 All four req_valid held high for 8 cycles with resp_ready=1 -> grants in order 0,1,2,3,0,1,2,3, one per cycle, and resp_id follows the same order.
REQ-035 resp_ready=0 for 5 cycles with the pipeline full -> req_ready=0, resp_o stable, perf_stall increments by 5; on release, two results drain in order.
REQ-036 a=0x7FE0000000000000 with b=10 -> resp_o=0x7FF0000000000000; a=NaN 0x7FF8000000000001 with any b -> resp_o=0x7FF8000000000001.
REQ-037 rst pulsed while 2 operations are in flight -> no resp_valid for those operations, and the first grant after reset goes to index 0.
